// File: rtl/col_frame_collector_if.sv
// Output stream of the column frame collector: one entry per column,
// transferred on out_valid && out_ready.
interface col_frame_collector_if #(
    parameter int CNT_COL      = 4,
    parameter int BITS_SIG_TDC = 16
);
    logic                    out_valid;
    logic                    out_ready;
    logic [CNT_COL-1:0]      out_col;
    logic [BITS_SIG_TDC-1:0] out_tdc;
    logic                    out_hit;
    logic                    out_last;

    modport master (
        output out_valid, out_col, out_tdc, out_hit, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_col, out_tdc, out_hit, out_last,
        output out_ready
    );
endinterface

// File: rtl/col_frame_collector.sv
// Double-banked column frame collector. One bank captures the first TDC
// sample per column for the current frame while the other bank is drained
// column by column over a valid/ready stream.
//
// Handshake: an entry moves when out_valid && out_ready at a rising edge.
// Once out_valid is high the entry fields stay stable and out_valid stays
// high until that transfer happens.
module col_frame_collector #(
    parameter int NUM_COL      = 16,
    parameter int CNT_COL      = 4,
    parameter int BITS_SIG_TDC = 16,
    parameter int PART_COLS    = 4
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic                    flag_col,
    input  logic [CNT_COL-1:0]      cnt_column_sys,
    input  logic                    finish_frame,
    input  logic                    part_work,
    input  logic                    tdc_valid,
    input  logic [BITS_SIG_TDC-1:0] tdc_data,
    col_frame_collector_if.master   o_stream,
    output logic                    busy,
    output logic [15:0]             frame_cnt,
    output logic [7:0]              overrun_cnt
);
    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    localparam logic [31:0] LEN_FULL = 32'(NUM_COL);
    localparam logic [31:0] LEN_PART = 32'(PART_COLS);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_act;       // 0 = bank A collects, 1 = bank B collects
    logic                    r_part_act;  // length select of the collecting bank
    logic                    r_part_drn;  // length select of the draining bank
    logic [NUM_COL-1:0]      r_hit [2];
    logic [BITS_SIG_TDC-1:0] r_data [2][NUM_COL];
    logic [CNT_COL-1:0]      r_idx;
    logic [15:0]             r_frame_cnt;
    logic [7:0]              r_overrun_cnt;

    logic                    w_drn;
    logic                    w_swap;
    logic                    w_overrun;
    logic                    w_xfer;
    logic                    w_last_xfer;
    logic                    w_is_last;
    logic [31:0]             w_len_drn;
    logic [31:0]             w_cap_len;
    logic                    w_cap;
    logic                    w_first;
    logic                    w_wr_bank;
    logic                    w_valid;
    logic                    w_last;
    logic                    w_hit;
    logic [CNT_COL-1:0]      w_col;
    logic [BITS_SIG_TDC-1:0] w_tdc;
    logic                    w_unused_flag;

    // flag_col is a scanner status strobe only; storage ignores it.
    assign w_unused_flag = flag_col;

    assign w_drn       = ~r_act;
    assign w_swap      = finish_frame && (r_state == ST_IDLE);
    assign w_overrun   = finish_frame && (r_state == ST_SEND);
    assign w_xfer      = (r_state == ST_SEND) && o_stream.out_ready;
    assign w_len_drn   = r_part_drn ? LEN_PART : LEN_FULL;
    assign w_is_last   = (32'(r_idx) == (w_len_drn - 32'd1));
    assign w_last_xfer = w_xfer && w_is_last;

    // A sample coinciding with finish_frame belongs to the next frame, so it
    // is judged against the newly latched length and lands in the bank that
    // collects from the next cycle on (always freshly cleared).
    assign w_cap_len = (finish_frame ? part_work : r_part_act) ? LEN_PART : LEN_FULL;
    assign w_cap     = tdc_valid && (32'(cnt_column_sys) < w_cap_len);
    assign w_first   = finish_frame || !r_hit[r_act][cnt_column_sys];
    assign w_wr_bank = w_swap ? w_drn : r_act;

    // Drain FSM state register.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Drain FSM next state and stream outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_valid     = 1'b0;
        w_last      = 1'b0;
        w_hit       = 1'b0;
        w_col       = '0;
        w_tdc       = '0;
        case (r_state)
            ST_IDLE: begin
                if (finish_frame) w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                w_valid = 1'b1;
                w_col   = r_idx;
                w_hit   = r_hit[w_drn][r_idx];
                w_tdc   = w_hit ? r_data[w_drn][r_idx] : '0;
                w_last  = w_is_last;
                if (w_last_xfer) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_stream.out_valid = w_valid;
    assign o_stream.out_col   = w_col;
    assign o_stream.out_tdc   = w_tdc;
    assign o_stream.out_hit   = w_hit;
    assign o_stream.out_last  = w_last;
    assign busy               = (r_state == ST_SEND);
    assign frame_cnt          = r_frame_cnt;
    assign overrun_cnt        = r_overrun_cnt;

    // Column pointer of the entry being drained.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst)              r_idx <= '0;
        else if (w_last_xfer) r_idx <= '0;
        else if (w_xfer)      r_idx <= r_idx + 1'b1;
    end

    // Bank roles and per-bank frame lengths.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_act      <= 1'b0;
            r_part_act <= 1'b0;
            r_part_drn <= 1'b0;
        end else if (finish_frame) begin
            if (w_swap) begin
                r_act      <= ~r_act;
                r_part_drn <= r_part_act;
            end
            r_part_act <= part_work;
        end
    end

    // Hit bits: cleared when a bank starts a frame or finishes draining;
    // the capture write comes last so a boundary sample survives the clear.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_hit[0] <= '0;
            r_hit[1] <= '0;
        end else begin
            if (w_swap)      r_hit[w_drn] <= '0;
            if (w_overrun)   r_hit[r_act] <= '0;
            if (w_last_xfer) r_hit[w_drn] <= '0;
            if (w_cap && w_first) r_hit[w_wr_bank][cnt_column_sys] <= 1'b1;
        end
    end

    // Sample storage; contents are qualified by the hit bits, so no reset.
    always_ff @(posedge CLK) begin
        if (w_cap && w_first) r_data[w_wr_bank][cnt_column_sys] <= tdc_data;
    end

    // Drained-frame and dropped-frame counters.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_frame_cnt   <= '0;
            r_overrun_cnt <= '0;
        end else begin
            if (w_last_xfer) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_overrun && (r_overrun_cnt != 8'hFF)) r_overrun_cnt <= r_overrun_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_col_frame_collector.sv
// Bench for col_frame_collector: directed frames with literal expectations
// plus a randomized run, all checked every cycle against a frame-level model.
module tb_col_frame_collector;
    localparam int NC = 16;
    localparam int CW = 4;
    localparam int DW = 16;
    localparam int PC = 4;
    localparam int EW = 1 + 1 + CW + DW;  // {last, hit, col, tdc}

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flag_col = 1'b0;
    logic [CW-1:0] cnt_column_sys = '0;
    logic          finish_frame = 1'b0;
    logic          part_work = 1'b0;
    logic          tdc_valid = 1'b0;
    logic [DW-1:0] tdc_data = '0;
    logic          busy;
    logic [15:0]   frame_cnt;
    logic [7:0]    overrun_cnt;

    col_frame_collector_if #(.CNT_COL(CW), .BITS_SIG_TDC(DW)) bus();

    col_frame_collector #(
        .NUM_COL(NC), .CNT_COL(CW), .BITS_SIG_TDC(DW), .PART_COLS(PC)
    ) dut (
        .CLK(clk),
        .rst(rst),
        .flag_col(flag_col),
        .cnt_column_sys(cnt_column_sys),
        .finish_frame(finish_frame),
        .part_work(part_work),
        .tdc_valid(tdc_valid),
        .tdc_data(tdc_data),
        .o_stream(bus),
        .busy(busy),
        .frame_cnt(frame_cnt),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    bit rand_ready = 1'b0;

    logic [EW-1:0] exp_q[$];       // entries still owed by the draining frame
    bit            m_hit [NC];     // frame being collected
    logic [DW-1:0] m_data [NC];
    int            m_len;
    int            m_frames;
    int            m_overruns;

    int got_col[$];
    int got_tdc[$];
    int got_hit[$];
    int got_last[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int c = 0; c < NC; c++) m_hit[c] = 1'b0;
        m_len      = NC;
        m_frames   = 0;
        m_overruns = 0;
    endtask

    // Effect of the coming rising edge, from the inputs now held stable.
    task automatic model_edge();
        bit            busy_m;
        logic [EW-1:0] e;
        logic [DW-1:0] d;
        int            col;
        busy_m = (exp_q.size() != 0);
        if (busy_m && bus.out_ready) begin
            e = exp_q.pop_front();
            if (e[EW-1]) m_frames = (m_frames + 1) % 65536;
        end
        if (finish_frame) begin
            if (!busy_m) begin
                for (int c = 0; c < m_len; c++) begin
                    d = m_hit[c] ? m_data[c] : '0;
                    e = {(c == m_len - 1), m_hit[c], CW'(c), d};
                    exp_q.push_back(e);
                end
            end else if (m_overruns < 255) begin
                m_overruns++;
            end
            for (int c = 0; c < NC; c++) m_hit[c] = 1'b0;
            m_len = part_work ? PC : NC;
        end
        col = int'(cnt_column_sys);
        if (tdc_valid && col < m_len && !m_hit[col]) begin
            m_hit[col]  = 1'b1;
            m_data[col] = tdc_data;
        end
    endtask

    // Compare process: outputs vs. model each cycle, then advance the model.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        bit            exp_valid;
        if (rst) begin
            model_reset();
        end else begin
            exp_valid = (exp_q.size() != 0);
            check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            check("busy", 32'(busy), 32'(exp_valid));
            check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
            check("overrun_cnt", 32'(overrun_cnt), 32'(m_overruns));
            if (exp_valid) begin
                e = exp_q[0];
                check("out_last", 32'(bus.out_last), 32'(e[EW-1]));
                check("out_hit", 32'(bus.out_hit), 32'(e[EW-2]));
                check("out_col", 32'(bus.out_col), 32'(e[DW+CW-1:DW]));
                check("out_tdc", 32'(bus.out_tdc), 32'(e[DW-1:0]));
            end
            if (bus.out_valid && bus.out_ready) begin
                got_col.push_back(int'(bus.out_col));
                got_tdc.push_back(int'(bus.out_tdc));
                got_hit.push_back(int'(bus.out_hit));
                got_last.push_back(int'(bus.out_last));
            end
            model_edge();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic send_sample(input int col, input logic [DW-1:0] data);
        cnt_column_sys = CW'(col);
        tdc_data       = data;
        tdc_valid      = 1'b1;
        tick();
        tdc_valid      = 1'b0;
    endtask

    task automatic end_frame(input logic next_part);
        part_work    = next_part;
        finish_frame = 1'b1;
        tick();
        finish_frame = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clear_got();
        got_col.delete();
        got_tdc.delete();
        got_hit.delete();
        got_last.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.out_ready = 1'b1;
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_col", 32'(bus.out_col), 32'd0);
        check("rst_out_tdc", 32'(bus.out_tdc), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_overrun_cnt", 32'(overrun_cnt), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Full frame; its close latches a partial length for the next frame.
        clear_got();
        for (int c = 0; c < NC; c++) send_sample(c, 16'(16'h100 + c));
        end_frame(1'b1);
        wait_drain();
        check("full_count", 32'(got_col.size()), 32'd16);
        check("full_col0_tdc", 32'(got_tdc[0]), 32'h100);
        check("full_col7_hit", 32'(got_hit[7]), 32'd1);
        check("full_col15_tdc", 32'(got_tdc[15]), 32'h10F);
        check("full_col14_last", 32'(got_last[14]), 32'd0);
        check("full_col15_last", 32'(got_last[15]), 32'd1);
        check("full_frame_cnt", 32'(frame_cnt), 32'd1);

        // Partial frame with sparse hits; col 9 is outside the frame.
        clear_got();
        send_sample(2, 16'hABCD);
        send_sample(9, 16'h9999);
        end_frame(1'b0);
        wait_drain();
        check("part_count", 32'(got_col.size()), 32'd4);
        check("part_col2_hit", 32'(got_hit[2]), 32'd1);
        check("part_col2_tdc", 32'(got_tdc[2]), 32'hABCD);
        check("part_col0_hit", 32'(got_hit[0]), 32'd0);
        check("part_col0_tdc", 32'(got_tdc[0]), 32'd0);
        check("part_col3_col", 32'(got_col[3]), 32'd3);
        check("part_col3_last", 32'(got_last[3]), 32'd1);

        // Duplicate sample plus backpressure on entry 5.
        clear_got();
        send_sample(5, 16'h1111);
        send_sample(5, 16'h2222);
        bus.out_ready = 1'b0;
        end_frame(1'b0);
        bus.out_ready = 1'b1;
        repeat (5) tick();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_col", 32'(bus.out_col), 32'd5);
            check("hold_tdc", 32'(bus.out_tdc), 32'h1111);
            tick();
        end
        bus.out_ready = 1'b1;
        wait_drain();
        check("dup_col5_tdc", 32'(got_tdc[5]), 32'h1111);
        check("dup_frame_cnt", 32'(frame_cnt), 32'd3);

        // Overrun: second frame closes while the first is still queued.
        clear_got();
        bus.out_ready = 1'b0;
        send_sample(1, 16'h0AAA);
        end_frame(1'b0);
        send_sample(3, 16'h0BBB);
        end_frame(1'b0);
        check("ovr_count", 32'(overrun_cnt), 32'd1);
        bus.out_ready = 1'b1;
        wait_drain();
        check("ovr_entries", 32'(got_col.size()), 32'd16);
        check("ovr_col1_tdc", 32'(got_tdc[1]), 32'h0AAA);
        check("ovr_col3_hit", 32'(got_hit[3]), 32'd0);
        check("ovr_frame_cnt", 32'(frame_cnt), 32'd4);

        // Sample in the finish_frame cycle goes to the following frame.
        clear_got();
        send_sample(3, 16'h0333);
        cnt_column_sys = '0;
        tdc_data       = 16'h0042;
        tdc_valid      = 1'b1;
        end_frame(1'b0);
        tdc_valid      = 1'b0;
        wait_drain();
        check("bnd_col0_absent", 32'(got_hit[0]), 32'd0);
        check("bnd_col3_hit", 32'(got_hit[3]), 32'd1);
        clear_got();
        end_frame(1'b0);
        wait_drain();
        check("bnd_col0_next_hit", 32'(got_hit[0]), 32'd1);
        check("bnd_col0_next_tdc", 32'(got_tdc[0]), 32'h0042);
        check("bnd_col3_next_hit", 32'(got_hit[3]), 32'd0);

        // Reset in the middle of a drain.
        clear_got();
        for (int c = 0; c < NC; c++) send_sample(c, 16'(16'h200 + c));
        end_frame(1'b0);
        repeat (3) tick();
        #1 rst = 1'b1;
        #1;
        check("mid_rst_transfers", 32'(got_col.size()), 32'd3);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_col", 32'(bus.out_col), 32'd0);
        check("mid_rst_tdc", 32'(bus.out_tdc), 32'd0);
        check("mid_rst_hit", 32'(bus.out_hit), 32'd0);
        check("mid_rst_last", 32'(bus.out_last), 32'd0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_got();
        send_sample(7, 16'h0777);
        end_frame(1'b0);
        wait_drain();
        check("post_rst_col7_tdc", 32'(got_tdc[7]), 32'h0777);
        check("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

        // Randomized traffic with random backpressure and frame boundaries.
        rand_ready = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            flag_col       = 1'($urandom_range(0, 1));
            tdc_valid      = ($urandom_range(0, 1) == 1);
            cnt_column_sys = CW'($urandom_range(0, NC - 1));
            tdc_data       = DW'($urandom);
            finish_frame   = ($urandom_range(0, 24) == 0);
            part_work      = ($urandom_range(0, 2) == 0);
            tick();
        end
        rand_ready     = 1'b0;
        tdc_valid      = 1'b0;
        finish_frame   = 1'b0;
        bus.out_ready  = 1'b1;
        wait_drain();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
